prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 137 +++++++++++++
 tb/tb_prog_loader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program loader: streams words into instruction memory, then runs the core.
// Optional macro PROG_LOADER_CHECKSUM_EN enables the XOR checksum register.
module prog_loader #(
    parameter int ADDR_W = 12,
    parameter int INST_W = 9,
    parameter int CYC_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    input  logic              in_valid,
    input  logic [INST_W-1:0] in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [INST_W-1:0] imem_wdata,
    output logic              core_reset,
    input  logic              core_done,
    output logic              busy,
    output logic              finished,
    output logic [CYC_W-1:0]  cycles,
    output logic [INST_W-1:0] checksum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RELEASE,
        S_RUN,
        S_DONE
    } state_e;

    localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);
    localparam logic [CYC_W-1:0]  ONE_C = CYC_W'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic              accept;
    logic              new_sess;

    // State, word counter, latched length and run-cycle counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            cyc_q   <= cyc_d;
        end
    end

    // Next-state logic and handshake decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        cyc_d    = cyc_q;
        accept   = 1'b0;
        new_sess = 1'b0;
        in_ready = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    new_sess = 1'b1;
                    len_d    = len;
                    cnt_d    = '0;
                    cyc_d    = '0;
                    state_d  = (len != '0) ? S_LOAD : S_RELEASE;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept = 1'b1;
                    // Last word holds the counter so it never passes len-1
                    if (cnt_q == len_q - ONE_A) begin
                        state_d = S_RELEASE;
                    end else begin
                        cnt_d = cnt_q + ONE_A;
                    end
                end
            end
            S_RELEASE: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (core_done) begin
                    state_d = S_DONE;
                end else if (cyc_q != '1) begin
                    cyc_d = cyc_q + ONE_C;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [INST_W-1:0] cks_q;

    // Running XOR of accepted words, cleared when a session starts
    always_ff @(posedge clk) begin
        if (!reset) begin
            cks_q <= '0;
        end else if (new_sess) begin
            cks_q <= '0;
        end else if (accept) begin
            cks_q <= cks_q ^ in_data;
        end
    end

    assign checksum = cks_q;
`else
    logic unused_sess;

    assign unused_sess = new_sess;
    assign checksum    = '0;
`endif

    assign imem_we    = accept;
    assign imem_addr  = accept ? cnt_q : '0;
    assign imem_wdata = accept ? in_data : '0;
    assign core_reset = (state_q != S_RUN);
    assign busy       = (state_q == S_LOAD) || (state_q == S_RELEASE)
                     || (state_q == S_RUN);
    assign finished   = (state_q == S_DONE);
    assign cycles     = cyc_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: write scoreboard plus state checks.
// A second instance with CYC_W=4 shares the stimulus to cover saturation.
module tb_prog_loader;

    localparam int AW = 12;
    localparam int IW = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] len;
    logic          in_valid;
    logic [IW-1:0] in_data;
    logic          core_done;

    logic          in_ready, imem_we, core_reset, busy, finished;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_wdata, checksum;
    logic [15:0]   cycles;

    logic          s_in_ready, s_imem_we, s_core_reset, s_busy, s_finished;
    logic [AW-1:0] s_imem_addr;
    logic [IW-1:0] s_imem_wdata, s_checksum;
    logic [3:0]    s_cycles;

    int n_chk = 0;
    int n_err = 0;

    logic [AW+IW-1:0] exp_q[$];
    logic [AW+IW-1:0] e_w;
    logic [AW-1:0]    a_mdl;
    logic [IW-1:0]    cks_mdl;

    always #5 clk = ~clk;

    prog_loader u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .core_reset(core_reset),
        .core_done (core_done),
        .busy      (busy),
        .finished  (finished),
        .cycles    (cycles),
        .checksum  (checksum)
    );

    prog_loader #(.CYC_W(4)) u_sat (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (s_in_ready),
        .imem_we   (s_imem_we),
        .imem_addr (s_imem_addr),
        .imem_wdata(s_imem_wdata),
        .core_reset(s_core_reset),
        .core_done (core_done),
        .busy      (s_busy),
        .finished  (s_finished),
        .cycles    (s_cycles),
        .checksum  (s_checksum)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_cks();
`ifdef PROG_LOADER_CHECKSUM_EN
        return 32'(cks_mdl);
`else
        return 32'd0;
`endif
    endfunction

    // Every write must match the oldest expected (addr,data)
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_we", 32'(imem_addr), 32'hffff_ffff);
            end else begin
                e_w = exp_q.pop_front();
                chk("wr_addr", 32'(imem_addr), 32'(e_w[AW+IW-1:IW]));
                chk("wr_data", 32'(imem_wdata), 32'(e_w[IW-1:0]));
            end
        end
    end

    task automatic start_sess(input logic [AW-1:0] l);
        start = 1'b1;
        len   = l;
        a_mdl   = '0;
        cks_mdl = '0;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [IW-1:0] w, input int gap);
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            tick();
            chk("gap_we", 32'(imem_we), 32'd0);
            chk("gap_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b1;
        in_data  = w;
        exp_q.push_back({a_mdl, w});
        a_mdl   = a_mdl + 1'b1;
        cks_mdl = cks_mdl ^ w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic release_run();
        chk("rel_busy", 32'(busy), 32'd1);
        chk("rel_ready", 32'(in_ready), 32'd0);
        chk("rel_core_rst", 32'(core_reset), 32'd1);
        tick();
        chk("run_core_rst", 32'(core_reset), 32'd0);
        chk("run_busy", 32'(busy), 32'd1);
    endtask

    task automatic finish_run();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("done_fin", 32'(finished), 32'd1);
        chk("sess_q_empty", 32'(exp_q.size()), 32'd0);
        chk("sess_cks", 32'(checksum), exp_cks());
    endtask

    logic [IW-1:0] basic_w [3];
    logic [IW-1:0] w;

    initial begin
        basic_w[0] = 9'h101;
        basic_w[1] = 9'h0AA;
        basic_w[2] = 9'h1FF;
        reset = 1'b0; start = 1'b0; len = '0;
        in_valid = 1'b0; in_data = '0; core_done = 1'b0;
        a_mdl = '0; cks_mdl = '0;
        tick(); tick(); tick();
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", 32'(imem_wdata), 32'd0);
        chk("rst_core_rst", 32'(core_reset), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fin", 32'(finished), 32'd0);
        chk("rst_cycles", 32'(cycles), 32'd0);
        chk("rst_cks", 32'(checksum), 32'd0);
        reset = 1'b1;
        tick();

        // Basic load of three back-to-back words, then a long run
        start_sess(12'd3);
        chk("load_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) send(basic_w[i], 0);
        release_run();
        for (int i = 1; i <= 183; i++) begin
            if (i == 50) start = 1'b1;
            tick();
            start = 1'b0;
            if (i == 20) begin
                chk("cyc20", 32'(cycles), 32'd20);
                chk("sat20", 32'(s_cycles), 32'd15);
            end
            if (i == 50) chk("start_ign_run", 32'(core_reset), 32'd0);
        end
        chk("cyc183_pre", 32'(cycles), 32'd183);
        finish_run();
        chk("done_cycles", 32'(cycles), 32'd183);
        chk("done_core_rst", 32'(core_reset), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("sat_done", 32'(s_cycles), 32'd15);
        tick(); tick();
        chk("done_hold_cyc", 32'(cycles), 32'd183);
        chk("done_hold_cks", 32'(checksum), exp_cks());

        // Stall: two words with 4-cycle gaps, started from DONE
        start_sess(12'd2);
        chk("stall_cks_clr", 32'(checksum), 32'd0);
        chk("stall_cyc_clr", 32'(cycles), 32'd0);
        send(9'h033, 4);
        send(9'h1C4, 4);
        release_run();
        tick(); tick();
        finish_run();
        chk("stall_cycles", 32'(cycles), 32'd2);

        // Zero length, core_done held high outside RUN
        core_done = 1'b1;
        start = 1'b1; len = '0; a_mdl = '0; cks_mdl = '0;
        tick();
        start = 1'b0;
        chk("z_we", 32'(imem_we), 32'd0);
        chk("z_fin", 32'(finished), 32'd0);
        release_run();
        tick();
        core_done = 1'b0;
        chk("z_fin_done", 32'(finished), 32'd1);
        chk("z_cycles", 32'(cycles), 32'd0);
        chk("z_cks", 32'(checksum), 32'd0);

        // Abort mid-load with reset, then restart from addr 0
        start_sess(12'd10);
        for (int i = 0; i < 5; i++) begin
            w = 9'(($urandom % 512));
            send(w, 0);
        end
        reset = 1'b0;
        tick();
        chk("abort_core_rst", 32'(core_reset), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(in_ready), 32'd0);
        start = 1'b1; len = 12'd3; in_valid = 1'b1; in_data = 9'h155;
        tick();
        chk("rst_start_ign", 32'(busy), 32'd0);
        chk("abort_cks", 32'(checksum), 32'd0);
        reset = 1'b1;
        in_data = 9'h1EE;
        start = 1'b1; len = 12'd10; a_mdl = '0; cks_mdl = '0;
        tick();
        start = 1'b0; in_valid = 1'b0;
        chk("restart_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 10; i++) begin
            w = 9'(($urandom % 512));
            send(w, (i == 6) ? 1 : 0);
        end
        release_run();
        tick();
        finish_run();
        chk("restart_cycles", 32'(cycles), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
